// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime_gen
//  Description : Complementary high/low-side PWM generator with enforced dead
//                time, shadowed timing words and sticky fault shutdown.
//  Revision    : 1.0  initial release
// ============================================================================

module pwm_deadtime_gen #(
    parameter int Dc_length = 13,
    parameter int MIN_DT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fault,
    input  logic [Dc_length-1:0] H_on,
    input  logic [Dc_length-1:0] L_on,
    input  logic [Dc_length-1:0] DeadTime,
    output logic                 HS_gate,
    output logic                 LS_gate,
    output logic                 period_start,
    output logic                 fault_flag,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HIGH = 3'd1,
        S_DT1  = 3'd2,
        S_LOW  = 3'd3,
        S_DT2  = 3'd4
    } state_t;

    // A zero-cycle dead phase cannot be timed, so the floor is at least one.
    localparam int                   c_MIN_DT_EFF = (MIN_DT < 1) ? 1 : MIN_DT;
    localparam logic [Dc_length-1:0] c_MIN_DT     = Dc_length'(c_MIN_DT_EFF);
    localparam logic [Dc_length-1:0] c_ONE        = Dc_length'(1);
    localparam logic [Dc_length-1:0] c_ZERO       = '0;

    state_t               r_state;
    logic [Dc_length-1:0] r_cnt;
    logic [Dc_length-1:0] r_h_s;
    logic [Dc_length-1:0] r_l_s;
    logic [Dc_length-1:0] r_dt_s;
    logic                 r_hs;
    logic                 r_ls;
    logic                 r_ps;
    logic                 r_flag;

    state_t               w_next_state;
    logic [Dc_length-1:0] w_next_cnt;
    logic                 w_capture;
    logic                 w_set_flag;
    logic                 w_cnt_zero;
    logic [Dc_length-1:0] w_h_dur_in;
    logic [Dc_length-1:0] w_dt_dur;
    logic [Dc_length-1:0] w_l_dur;
    logic                 w_next_hs;
    logic                 w_next_ls;

    assign w_cnt_zero = (r_cnt == c_ZERO);
    // HIGH duration is taken from the live input because it is loaded on the
    // same edge that captures the shadow copy.
    assign w_h_dur_in = (H_on == c_ZERO) ? c_ONE : H_on;
    assign w_dt_dur   = (r_dt_s < c_MIN_DT) ? c_MIN_DT : r_dt_s;
    assign w_l_dur    = (r_l_s == c_ZERO) ? c_ONE : r_l_s;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        w_set_flag   = 1'b0;
        if (fault) begin
            w_next_state = S_IDLE;
            w_next_cnt   = c_ZERO;
            w_set_flag   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && !r_flag) begin
                        w_next_state = S_HIGH;
                        w_next_cnt   = w_h_dur_in - c_ONE;
                        w_capture    = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_cnt_zero) begin
                        w_next_state = S_DT1;
                        w_next_cnt   = w_dt_dur - c_ONE;
                    end else begin
                        w_next_cnt   = r_cnt - c_ONE;
                    end
                end
                S_DT1: begin
                    if (w_cnt_zero) begin
                        w_next_state = S_LOW;
                        w_next_cnt   = w_l_dur - c_ONE;
                    end else begin
                        w_next_cnt   = r_cnt - c_ONE;
                    end
                end
                S_LOW: begin
                    if (w_cnt_zero) begin
                        w_next_state = S_DT2;
                        w_next_cnt   = w_dt_dur - c_ONE;
                    end else begin
                        w_next_cnt   = r_cnt - c_ONE;
                    end
                end
                S_DT2: begin
                    if (w_cnt_zero) begin
                        if (enable) begin
                            w_next_state = S_HIGH;
                            w_next_cnt   = w_h_dur_in - c_ONE;
                            w_capture    = 1'b1;
                        end else begin
                            w_next_state = S_IDLE;
                            w_next_cnt   = c_ZERO;
                        end
                    end else begin
                        w_next_cnt   = r_cnt - c_ONE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = c_ZERO;
                end
            endcase
        end
    end

    // Gates are computed from the next state so they register in lock-step
    // with it; a zero on-time keeps the phase but suppresses the drive.
    assign w_next_hs = (w_next_state == S_HIGH) &&
                       (w_capture ? (H_on != c_ZERO) : (r_h_s != c_ZERO));
    assign w_next_ls = (w_next_state == S_LOW) && (r_l_s != c_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= c_ZERO;
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
            r_ps    <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_hs    <= w_next_hs;
            r_ls    <= w_next_ls;
            r_ps    <= w_capture;
            if (w_set_flag) begin
                r_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_s  <= c_ZERO;
            r_l_s  <= c_ZERO;
            r_dt_s <= c_ZERO;
        end else if (w_capture) begin
            r_h_s  <= H_on;
            r_l_s  <= L_on;
            r_dt_s <= DeadTime;
        end
    end

    assign HS_gate      = r_hs;
    assign LS_gate      = r_ls;
    assign period_start = r_ps;
    assign fault_flag   = r_flag;
    assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/pwm_deadtime_gen.md
PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 SHALL have parameter Dc_length, default 13, giving the width of the timing words and counter.
REQ-002 SHALL have parameter MIN_DT, default 2, giving the minimum enforced dead time in clk cycles.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 fault  input  1  synchronous shutdown request.
REQ-007 H_on  input  Dc_length  high-side on time in cycles, from the concatenation stage.
REQ-008 L_on  input  Dc_length  low-side on time in cycles, from the concatenation stage.
REQ-009 DeadTime  input  Dc_length  dead time in cycles, from the concatenation stage.
REQ-010 HS_gate  output  1  high-side gate drive, registered.
REQ-011 LS_gate  output  1  low-side gate drive, registered.
REQ-012 period_start  output  1  one-cycle pulse in the first HIGH cycle of each period.
REQ-013 fault_flag  output  1  sticky fault indication.
REQ-014 busy  output  1  1 whenever state != IDLE.

Function
REQ-015 SHALL implement a state machine with states IDLE, HIGH, DT1, LOW and DT2.
REQ-016 IDLE->HIGH SHALL occur on the first edge with enable=1 and fault_flag=0.
REQ-017 H_on, L_on and DeadTime SHALL be captured into shadow registers on every edge that enters HIGH; input changes at any other time SHALL NOT affect the period in progress.
REQ-018 Phase durations SHALL be: HIGH = max(H_on_s,1) cycles; DT1 = DT2 = max(DeadTime_s,MIN_DT) cycles; LOW = max(L_on_s,1) cycles.
REQ-019 A single down-counter of width Dc_length SHALL time the phases: loaded with duration-1 on phase entry, with the phase ending on the edge where the count is 0.
REQ-020 Transitions SHALL be HIGH->DT1->LOW->DT2 in order; at the end of DT2, the next state SHALL be HIGH if enable=1, else IDLE.
REQ-021 Deasserting enable mid-period SHALL NOT cut the period short; the period SHALL complete through DT2 and then go to IDLE.
REQ-022 HS_gate SHALL be 1 exactly in the cycles where state==HIGH and H_on_s!=0; otherwise it SHALL be 0.
REQ-023 LS_gate SHALL be 1 exactly in the cycles where state==LOW and L_on_s!=0; otherwise it SHALL be 0.
REQ-024 HS_gate and LS_gate SHALL never be 1 in the same cycle, under any input sequence.
REQ-025 Both gates SHALL be 0 for at least MIN_DT cycles between any HS_gate fall and the next LS_gate rise, and likewise between any LS_gate fall and the next HS_gate rise.
REQ-026 On an edge with fault=1, from any state:
  - state SHALL go to IDLE;
  - both gates SHALL go to 0;
  - fault_flag SHALL be set to 1.
REQ-027 Fault SHALL have priority over enable and over all phase transitions.
REQ-028 Once fault_flag=1, the block SHALL remain in IDLE regardless of enable; only rst SHALL clear fault_flag.
REQ-029 period_start SHALL be 1 only in the first cycle of each HIGH phase.
REQ-030 Period length SHALL equal the sum of the four phase durations, with no idle cycle between back-to-back periods.

Reset
REQ-031 While rst=1, regardless of clk:
  - state=IDLE;
  - HS_gate=0, LS_gate=0;
  - period_start=0, busy=0;
  - fault_flag=0;
  - counter=0;
  - shadow registers = 0.
REQ-032 Assertion of rst mid-period SHALL drive both gates to 0 immediately, without waiting for a clock edge.
REQ-033 After rst deasserts, the block SHALL start a new period only on an edge with enable=1.

Verification
REQ-034 H_on=5, L_on=3, DeadTime=2, enable held at 1 -> HS_gate 1 for 5 cycles, both gates 0 for 2, LS_gate 1 for 3, both gates 0 for 2; period_start pulses every 12 cycles.
REQ-035 H_on changed from 5 to 8 during LOW of period n -> period n keeps HS_gate high for 5 cycles; period n+1 keeps HS_gate high for 8 cycles.
REQ-036 DeadTime=0 with MIN_DT=2; H_on=0 -> each dead phase lasts 2 cycles; the HIGH phase lasts 1 cycle with HS_gate=0; HS_gate and LS_gate are never both 1.
REQ-037 enable dropped in cycle 2 of HIGH with H_on=5, L_on=3, DeadTime=2 -> the period completes (12 cycles total), then IDLE with busy=0; no further period_start pulse.
REQ-038 fault pulsed for one cycle during HIGH -> HS_gate=0 on the next edge, fault_flag=1, and the block stays in IDLE with enable=1 until rst is applied.
REQ-039 rst asserted between clock edges while LS_gate=1 -> LS_gate=0 immediately; after rst is released, the next period starts on the first edge with enable=1.
